score_keeper: RTL

- Sits between the symbol generator and the 7-seg display path, alongside the level controller.
- Counts target ("special") symbols as they are generated during the game period.
- After the answer period closes, compares the player's count (userCount) with the true count and produces gameCount, countDifference (score), loss and a running total score.
- Replaces the constant gameCount currently fed to the display.

---
 rtl/game_pkg.sv | 28 ++
 rtl/score_keeper_if.sv | 40 ++++
 rtl/score_keeper_abs_diff_sat.sv | 44 ++++
 rtl/score_keeper.sv | 135 +++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Constants and the FSM state type shared by the score keeper, its bus
// interface, its difference/score helper and the testbench.
//   COUNT_W       width of symbol counts and count difference
//   LEVEL_W       width of the level input
//   TOTAL_W       width of the accumulated score
//   TOL_START     allowed |difference| below TIGHTEN_LEVEL
//   TIGHTEN_LEVEL first level with zero tolerance
//   MAX_PTS       points per round before the difference is subtracted
// ---------------------------------------------------------------------------
package game_pkg;

    localparam int COUNT_W       = 7;
    localparam int LEVEL_W       = 5;
    localparam int TOTAL_W       = 10;
    localparam int TOL_START     = 2;
    localparam int TIGHTEN_LEVEL = 8;
    localparam int MAX_PTS       = 10;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COUNTING = 2'd1,
        ANSWER   = 2'd2,
        RESULT   = 2'd3
    } state_t;

endpackage

// File: rtl/score_keeper_if.sv
// ---------------------------------------------------------------------------
// score_keeper_if
// Groups the game timing pulses, symbol strobe, player inputs and the score
// outputs of score_keeper.
//   master : driver side (game sequencer / testbench), drives the pulses,
//            symbol strobe, userCount and level, reads the results.
//   slave  : score_keeper side.
// ---------------------------------------------------------------------------
interface score_keeper_if;
    import game_pkg::*;

    logic                gamePeriodB;
    logic                symValid;
    logic                specialCount;
    logic                answerPeriodB;
    logic                postPeriodB;
    logic                levelChngB;
    logic [COUNT_W-1:0]  userCount;
    logic [LEVEL_W-1:0]  level;

    logic [COUNT_W-1:0]  gameCount;
    logic [COUNT_W-1:0]  countDifference;
    logic                loss;
    logic                scoreValid;
    logic [TOTAL_W-1:0]  totalScore;
    logic [1:0]          phase;

    modport master (
        output gamePeriodB, symValid, specialCount, answerPeriodB,
               postPeriodB, levelChngB, userCount, level,
        input  gameCount, countDifference, loss, scoreValid, totalScore, phase
    );

    modport slave (
        input  gamePeriodB, symValid, specialCount, answerPeriodB,
               postPeriodB, levelChngB, userCount, level,
        output gameCount, countDifference, loss, scoreValid, totalScore, phase
    );

endinterface

// File: rtl/score_keeper_abs_diff_sat.sv
// ---------------------------------------------------------------------------
// abs_diff_sat
// Combinational |i_a - i_b| and the candidate new total score
// i_total + max(MAX_PTS - diff, 0), saturating at 2^TOTAL_W-1.
//   i_a, i_b     counts to compare (COUNT_W)
//   i_total      current accumulated score (TOTAL_W)
//   o_diff       absolute difference (COUNT_W)
//   o_total_inc  total after adding this round's points, saturated
// ---------------------------------------------------------------------------
module abs_diff_sat
    import game_pkg::*;
(
    input  logic [COUNT_W-1:0] i_a,
    input  logic [COUNT_W-1:0] i_b,
    input  logic [TOTAL_W-1:0] i_total,
    output logic [COUNT_W-1:0] o_diff,
    output logic [TOTAL_W-1:0] o_total_inc
);

    localparam logic [COUNT_W:0] MAX_PTS_C = (COUNT_W+1)'(MAX_PTS);

    logic [COUNT_W:0]   w_a_ext;
    logic [COUNT_W:0]   w_b_ext;
    logic [COUNT_W:0]   w_sub;
    logic [COUNT_W:0]   w_pts;
    logic [TOTAL_W-1:0] w_pts_ext;
    logic [TOTAL_W:0]   w_sum;

    assign w_a_ext = {1'b0, i_a};
    assign w_b_ext = {1'b0, i_b};

    // Subtract the smaller from the larger so the magnitude never wraps;
    // the extra bit only keeps the intermediate honest, the result fits COUNT_W.
    assign w_sub  = (w_a_ext >= w_b_ext) ? (w_a_ext - w_b_ext) : (w_b_ext - w_a_ext);
    assign o_diff = w_sub[COUNT_W-1:0];

    // A difference of MAX_PTS or more earns nothing rather than going negative.
    assign w_pts     = (w_sub < MAX_PTS_C) ? (MAX_PTS_C - w_sub) : '0;
    assign w_pts_ext = {{(TOTAL_W-COUNT_W-1){1'b0}}, w_pts};

    assign w_sum       = {1'b0, i_total} + {1'b0, w_pts_ext};
    assign o_total_inc = w_sum[TOTAL_W] ? {TOTAL_W{1'b1}} : w_sum[TOTAL_W-1:0];

endmodule

// File: rtl/score_keeper.sv
// ---------------------------------------------------------------------------
// score_keeper
// Counts target symbols during the game period, then judges the player's
// count once the answer period closes and keeps a saturating total score.
//   Clk100M : system clock
//   reset   : synchronous active-high reset
//   bus     : score_keeper_if.slave
//             in : gamePeriodB, symValid, specialCount, answerPeriodB,
//                  postPeriodB, levelChngB, userCount, level
//             out: gameCount, countDifference, loss, scoreValid,
//                  totalScore, phase (encoded FSM state)
// ---------------------------------------------------------------------------
module score_keeper
    import game_pkg::*;
(
    input  logic                 Clk100M,
    input  logic                 reset,
    score_keeper_if.slave        bus
);

    localparam logic [LEVEL_W-1:0] TIGHTEN_C = LEVEL_W'(TIGHTEN_LEVEL);
    localparam logic [COUNT_W-1:0] TOL_C     = COUNT_W'(TOL_START);
    localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

    state_t              r_state;
    state_t              w_state_next;

    logic [COUNT_W-1:0]  r_game_count;
    logic [COUNT_W-1:0]  r_count_diff;
    logic                r_loss;
    logic                r_score_valid;
    logic [TOTAL_W-1:0]  r_total;

    logic                w_start;
    logic                w_count_en;
    logic                w_judge;
    logic [1:0]          w_phase;

    logic [COUNT_W-1:0]  w_diff;
    logic [TOTAL_W-1:0]  w_total_inc;
    logic [COUNT_W-1:0]  w_tol;
    logic                w_loss;

    abs_diff_sat u_abs_diff_sat (
        .i_a         (bus.userCount),
        .i_b         (r_game_count),
        .i_total     (r_total),
        .o_diff      (w_diff),
        .o_total_inc (w_total_inc)
    );

    assign w_tol  = (bus.level < TIGHTEN_C) ? TOL_C : '0;
    assign w_loss = (w_diff > w_tol);

    // State register
    always_ff @(posedge Clk100M) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (bus.gamePeriodB) w_state_next = COUNTING;
            end
            COUNTING: begin
                if (bus.answerPeriodB) w_state_next = ANSWER;
            end
            ANSWER: begin
                if (bus.postPeriodB) w_state_next = RESULT;
            end
            RESULT: begin
                // A lost round is terminal until reset.
                if (!r_loss && (bus.levelChngB || bus.gamePeriodB))
                    w_state_next = COUNTING;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Output / datapath-control decode
    always_comb begin
        w_start    = 1'b0;
        w_count_en = 1'b0;
        w_judge    = 1'b0;
        w_phase    = r_state;
        case (r_state)
            IDLE:     w_start    = bus.gamePeriodB;
            // The strobe coinciding with answerPeriodB still counts.
            COUNTING: w_count_en = bus.symValid && bus.specialCount;
            ANSWER:   w_judge    = bus.postPeriodB;
            RESULT:   w_start    = !r_loss && (bus.levelChngB || bus.gamePeriodB);
            default:  w_start    = 1'b0;
        endcase
    end

    // Counters and judged results
    always_ff @(posedge Clk100M) begin
        if (reset) begin
            r_game_count  <= '0;
            r_count_diff  <= '0;
            r_loss        <= 1'b0;
            r_score_valid <= 1'b0;
            r_total       <= '0;
        end else begin
            if (w_start) begin
                r_game_count  <= '0;
                r_count_diff  <= '0;
                r_score_valid <= 1'b0;
            end else if (w_count_en && (r_game_count != COUNT_MAX)) begin
                r_game_count <= r_game_count + 1'b1;
            end

            if (w_judge) begin
                r_count_diff  <= w_diff;
                r_loss        <= w_loss;
                r_score_valid <= 1'b1;
                if (!w_loss) r_total <= w_total_inc;
            end
        end
    end

    assign bus.gameCount       = r_game_count;
    assign bus.countDifference = r_count_diff;
    assign bus.loss            = r_loss;
    assign bus.scoreValid      = r_score_valid;
    assign bus.totalScore      = r_total;
    assign bus.phase           = w_phase;

endmodule
